// File: rtl/datapath_pkg.sv
// Shared definitions for the memory-side datapath: default widths, the default
// handshake timeout, and the memory-interface FSM state type.
package datapath_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_ADDR_WIDTH     = 9;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts wait cycles of an outstanding memory request and flags the edge on
// which the count would reach TIMEOUT_CYCLES.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Saturates at TIMEOUT_CYCLES so a stray enable can never wrap it.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != CNT_W'(TIMEOUT_CYCLES))) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mdr_mem_interface.sv
// MAR/MDR stage with a req/ack RAM handshake; reports busy/done/err so the
// control unit can stall while an access is outstanding.
module mdr_mem_interface
    import datapath_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    input  logic                  MARin,
    input  logic                  MDRin,
    input  logic                  rd_start,
    input  logic                  wr_start,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] BusMuxIn_MDR,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    mem_state_e            state_q;
    mem_state_e            state_d;
    logic [ADDR_WIDTH-1:0] mar_q;
    logic [ADDR_WIDTH-1:0] mar_d;
    logic [DATA_WIDTH-1:0] mdr_q;
    logic [DATA_WIDTH-1:0] mdr_d;
    logic                  done_q;
    logic                  done_d;
    logic                  err_q;
    logic                  err_d;
    logic                  idle;
    logic                  expired;

    assign idle = (state_q == IDLE);

    // Only un-acked wait cycles advance the timer, so an ack on the expiry edge wins.
    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (clr_n),
        .clear_i  (idle),
        .enable_i (!idle && !mem_ack),
        .expired_o(expired)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rd_start) begin
                    state_d = RD_WAIT;
                end else if (wr_start) begin
                    state_d = WR_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (mem_ack || expired) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = !idle;
        mem_req = !idle;
        mem_we  = (state_q == WR_WAIT);
    end

    // MAR/MDR only move in IDLE or on a read ack, keeping the request stable.
    always_comb begin
        mar_d  = mar_q;
        mdr_d  = mdr_q;
        done_d = 1'b0;
        err_d  = err_q;
        if (idle) begin
            if (MARin) begin
                mar_d = BusMuxOut[ADDR_WIDTH-1:0];
            end
            if (MDRin) begin
                mdr_d = BusMuxOut;
            end
            if (rd_start || wr_start) begin
                err_d = 1'b0;
            end
        end else if (mem_ack) begin
            done_d = 1'b1;
            if (state_q == RD_WAIT) begin
                mdr_d = mem_rdata;
            end
        end else if (expired) begin
            done_d = 1'b1;
            err_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mar_q  <= '0;
            mdr_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            mar_q  <= mar_d;
            mdr_q  <= mdr_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign mem_addr     = mar_q;
    assign mem_wdata    = mdr_q;
    assign BusMuxIn_MDR = mdr_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_mdr_mem_interface.sv
// Scoreboard bench for mdr_mem_interface: the driver predicts each access from
// a register/RAM model, and a monitor checks it when done pulses.
module tb_mdr_mem_interface;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int T  = 16;

    logic          clk;
    logic          clr_n;
    logic [DW-1:0] BusMuxOut;
    logic          MARin;
    logic          MDRin;
    logic          rd_start;
    logic          wr_start;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] BusMuxIn_MDR;
    logic          busy;
    logic          done;
    logic          err;

    mdr_mem_interface #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .BusMuxOut   (BusMuxOut),
        .MARin       (MARin),
        .MDRin       (MDRin),
        .rd_start    (rd_start),
        .wr_start    (wr_start),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .BusMuxIn_MDR(BusMuxIn_MDR),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            cycles;
        logic [DW-1:0] mdr;
        logic          err;
    } exp_t;

    exp_t          expQ[$];
    int            checks = 0;
    int            errors = 0;
    logic [AW-1:0] mMar;
    logic [DW-1:0] mMdr;
    logic          mErr;
    logic [DW-1:0] ram [0:(1<<AW)-1];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idleInputs();
        BusMuxOut = $urandom;
        MARin     = 1'b0;
        MDRin     = 1'b0;
        rd_start  = 1'b0;
        wr_start  = 1'b0;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
    endtask

    task automatic loadCycle(input bit marIn, input bit mdrIn, input logic [DW-1:0] val);
        idleInputs();
        BusMuxOut = val;
        MARin     = marIn;
        MDRin     = mdrIn;
        if (marIn) mMar = val[AW-1:0];
        if (mdrIn) mMdr = val;
        @(negedge clk);
    endtask

    // delay = un-acked request cycles before the ack; delay >= T never acks.
    task automatic applyStimulus(input bit marIn, input bit mdrIn, input logic [DW-1:0] val,
                                 input bit rd, input bit wr, input int delay);
        exp_t e;
        int   cycles;
        bit   ack;
        idleInputs();
        BusMuxOut = val;
        MARin     = marIn;
        MDRin     = mdrIn;
        rd_start  = rd;
        wr_start  = wr;
        if (marIn) mMar = val[AW-1:0];
        if (mdrIn) mMdr = val;
        e.addr  = mMar;
        e.we    = wr && !rd;
        e.wdata = mMdr;
        if (delay < T) begin
            cycles = delay + 1;
            if (rd) mMdr = ram[mMar];
            else    ram[mMar] = mMdr;
            mErr = 1'b0;
        end else begin
            cycles = T;
            mErr   = 1'b1;
        end
        e.cycles = cycles;
        e.mdr    = mMdr;
        e.err    = mErr;
        expQ.push_back(e);
        @(negedge clk);
        checkOutput("busy_after_start", busy, 1);
        checkOutput("err_cleared_by_start", err, 0);
        for (int k = 1; k <= cycles; k++) begin
            BusMuxOut = $urandom;
            MARin     = 1'($urandom_range(0, 1));
            MDRin     = 1'($urandom_range(0, 1));
            rd_start  = 1'($urandom_range(0, 1));
            wr_start  = 1'($urandom_range(0, 1));
            ack       = (delay < T) && (k == cycles);
            mem_ack   = ack;
            mem_rdata = (ack && rd) ? ram[e.addr] : $urandom;
            @(negedge clk);
        end
        idleInputs();
    endtask

    int            reqCycles = 0;
    logic          capWe;
    logic [AW-1:0] capAddr;
    logic [DW-1:0] capWdata;
    bit            unstable;
    exp_t          me;

    // Captures the request as the RAM sees it and scores it on the done pulse.
    always @(negedge clk) begin
        if (!clr_n) begin
            reqCycles = 0;
        end else begin
            if (mem_req) begin
                if (reqCycles == 0) begin
                    capWe    = mem_we;
                    capAddr  = mem_addr;
                    capWdata = mem_wdata;
                    unstable = 1'b0;
                end else if (mem_we !== capWe || mem_addr !== capAddr || mem_wdata !== capWdata) begin
                    unstable = 1'b1;
                end
                reqCycles++;
            end
            if (done) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done actual=1 expected=0 at %0t", $time);
                end else begin
                    me = expQ.pop_front();
                    checkOutput("req_we", capWe, me.we);
                    checkOutput("req_addr", capAddr, me.addr);
                    checkOutput("req_wdata", capWdata, me.wdata);
                    checkOutput("req_cycles", reqCycles, me.cycles);
                    checkOutput("req_stable", unstable, 0);
                    checkOutput("mdr_after_access", BusMuxIn_MDR, me.mdr);
                    checkOutput("err_after_access", err, me.err);
                    checkOutput("busy_in_done_cycle", busy, 0);
                end
                reqCycles = 0;
            end
        end
    end

    function automatic logic [DW-1:0] randVal();
        logic [DW-1:0] v;
        v      = $urandom;
        v[AW-1:0] = AW'($urandom_range(0, 15));
        return v;
    endfunction

    initial begin
        bit rd;
        bit wr;
        int kind;
        int delay;
        for (int i = 0; i < (1 << AW); i++) ram[i] = $urandom;
        mMar  = '0;
        mMdr  = '0;
        mErr  = 1'b0;
        clr_n = 1'b0;
        idleInputs();
        repeat (3) @(negedge clk);
        checkOutput("reset_mem_req", mem_req, 0);
        checkOutput("reset_mem_we", mem_we, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_mdr", BusMuxIn_MDR, 0);
        checkOutput("reset_mar", mem_addr, 0);
        #2 clr_n = 1'b1;
        @(negedge clk);

        loadCycle(1'b0, 1'b1, 32'hA5A5_A5A5);
        idleInputs();
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        mem_ack  = 1'b0;
        @(negedge clk);
        checkOutput("req_before_reset", mem_req, 1);
        #2 clr_n = 1'b0;
        #1;
        checkOutput("midreset_mem_req", mem_req, 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_mdr", BusMuxIn_MDR, 0);
        checkOutput("midreset_err", err, 0);
        @(negedge clk);
        #2 clr_n = 1'b1;
        mMar = '0;
        mMdr = '0;
        mErr = 1'b0;
        expQ.delete();
        idleInputs();
        @(negedge clk);

        loadCycle(1'b1, 1'b0, 32'h0000_0042);
        loadCycle(1'b0, 1'b1, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, $urandom, 1'b0, 1'b1, 2);
        ram[9'h042] = 32'h1234_5678;
        applyStimulus(1'b0, 1'b0, $urandom, 1'b1, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, $urandom, 1'b1, 1'b0, T);
        applyStimulus(1'b0, 1'b0, $urandom, 1'b1, 1'b0, T - 1);
        applyStimulus(1'b1, 1'b0, {$urandom_range(0, 255), 15'h0, 9'h007}, 1'b1, 1'b1, 3);
        @(negedge clk);

        repeat (200) begin
            repeat ($urandom_range(0, 2)) loadCycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), randVal());
            kind  = $urandom_range(0, 3);
            rd    = (kind != 1);
            wr    = (kind == 1) || (kind == 2);
            delay = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 1, T + 2) : $urandom_range(0, 5);
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), randVal(), rd, wr, delay);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
